// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmit path.
package ps2_pkg;

    typedef enum logic [3:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        PARITY,
        STOP,
        ACK,
        DONE,
        ERROR
    } ps2_state_t;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Multi-stage synchroniser for one PS/2 line plus a falling-edge strobe.
// Stages reset to 1 (idle bus level) so reset release never produces a false edge.
module ps2_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '1;
            prev <= 1'b1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign level = sync[SYNC_STAGES-1];
    assign fall  = prev & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, start, 8 data, odd parity, stop, ACK).
// Build option: define PS2_TX_ACK_CHECK_EN to turn a missing device ACK into tx_error.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_PRE  = IW'(INHIBIT_CYCLES - 2);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic clk_level, clk_fall, dat_level, dat_fall_unused;

    ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clk(CLOCK_50), .rst(reset), .din(ps2_clk_in), .level(clk_level), .fall(clk_fall)
    );
    ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dat (
        .clk(CLOCK_50), .rst(reset), .din(ps2_dat_in), .level(dat_level), .fall(dat_fall_unused)
    );

    ps2_state_t     state, state_n;
    logic [IW-1:0]  inh_cnt, inh_n;
    logic [TW-1:0]  tmo_cnt, tmo_n;
    logic [3:0]     bit_cnt, bit_n;
    logic [10:0]    frame, frame_n;
    logic           ack_bad, ack_bad_n;
    logic           clk_oe_n, dat_oe_n;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            inh_cnt    <= '0;
            tmo_cnt    <= '0;
            bit_cnt    <= '0;
            frame      <= '0;
            ack_bad    <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_ready   <= 1'b1;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
        end else begin
            state      <= state_n;
            inh_cnt    <= inh_n;
            tmo_cnt    <= tmo_n;
            bit_cnt    <= bit_n;
            frame      <= frame_n;
            ack_bad    <= ack_bad_n;
            ps2_clk_oe <= clk_oe_n;
            ps2_dat_oe <= dat_oe_n;
            tx_ready   <= (state_n == IDLE);
            tx_done    <= (state_n == DONE);
            tx_error   <= (state_n == ERROR);
        end
    end

    // Outputs are registered, so every *_n value is what the pins show next cycle.
    always_comb begin
        state_n   = state;
        inh_n     = inh_cnt;
        tmo_n     = tmo_cnt;
        bit_n     = bit_cnt;
        frame_n   = frame;
        ack_bad_n = ack_bad;
        clk_oe_n  = 1'b0;
        dat_oe_n  = ps2_dat_oe;
        case (state)
            IDLE: begin
                dat_oe_n = 1'b0;
                if (tx_valid) begin
                    frame_n   = {1'b1, odd_parity(tx_data), tx_data, 1'b0};
                    inh_n     = '0;
                    ack_bad_n = 1'b0;
                    clk_oe_n  = 1'b1;
                    state_n   = INHIBIT;
                end
            end
            INHIBIT: begin
                inh_n    = inh_cnt + 1'b1;
                clk_oe_n = 1'b1;
                dat_oe_n = (inh_cnt == INH_PRE);
                if (inh_cnt == INH_LAST) begin
                    clk_oe_n = 1'b0;
                    dat_oe_n = 1'b1;
                    tmo_n    = '0;
                    bit_n    = '0;
                    state_n  = REQ;
                end
            end
            REQ, DATA, PARITY, STOP, ACK: begin
                tmo_n = tmo_cnt + 1'b1;
                if (tmo_cnt == TMO_LAST) begin
                    dat_oe_n = 1'b0;
                    state_n  = ERROR;
                end else if (state == ACK) begin
                    if (bit_cnt == 4'd10 && clk_fall) begin
                        bit_n     = 4'd11;
                        ack_bad_n = dat_level;
                    end else if (bit_cnt == 4'd11 && clk_level && dat_level) begin
`ifdef PS2_TX_ACK_CHECK_EN
                        state_n = ack_bad ? ERROR : DONE;
`else
                        state_n = DONE;
`endif
                    end
                end else if (clk_fall) begin
                    // frame[0] is the start bit already on the line; edge n drives frame[n]
                    bit_n    = bit_cnt + 1'b1;
                    dat_oe_n = ~frame[bit_n];
                    case (bit_n)
                        4'd8:    state_n = PARITY;
                        4'd9:    state_n = STOP;
                        4'd10:   state_n = ACK;
                        default: state_n = DATA;
                    endcase
                end
            end
            DONE:    begin dat_oe_n = 1'b0; state_n = IDLE; end
            ERROR:   begin dat_oe_n = 1'b0; state_n = IDLE; end
            default: begin dat_oe_n = 1'b0; state_n = IDLE; end
        endcase
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural PS/2 device and a frame scoreboard.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 600;
    localparam int TMO = 1000;
    localparam int H   = 20;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_dat_oe, tx_done, tx_error;
    logic       dev_clk = 1'b1, dev_dat = 1'b1;
    logic       bus_clk, bus_dat;

    assign bus_clk = ps2_clk_oe ? 1'b0 : dev_clk;
    assign bus_dat = ps2_dat_oe ? 1'b0 : dev_dat;

    always #10 CLOCK_50 = ~CLOCK_50;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .ps2_clk_in(bus_clk), .ps2_dat_in(bus_dat),
        .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .tx_done(tx_done), .tx_error(tx_error)
    );

    typedef struct {
        logic [7:0] data;
        logic       ack;
        logic       par;
        logic       exp_done;
    } vec_t;

    typedef struct {
        int         inh;
        int         inh_dat;
        logic       start;
        logic [9:0] bits;
    } rx_t;

    vec_t exp_q[$];
    rx_t  rx_q[$];
    int   checks = 0, errors = 0;
    int   done_cnt = 0, err_cnt = 0, frame_starts = 0;
    logic clk_oe_d = 1'b0;

`ifdef PS2_TX_ACK_CHECK_EN
    localparam logic NACK_DONE = 1'b0;
`else
    localparam logic NACK_DONE = 1'b1;
`endif

    always @(negedge CLOCK_50) begin
        if (tx_done)  done_cnt <= done_cnt + 1;
        if (tx_error) err_cnt  <= err_cnt + 1;
        if (ps2_clk_oe && !clk_oe_d) frame_starts <= frame_starts + 1;
        clk_oe_d <= ps2_clk_oe;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge CLOCK_50);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge CLOCK_50);
        tx_valid = 1'b0;
        chk("ready_low_after_accept", int'(tx_ready), 0);
    endtask

    // Device model; call while the host is (about to be) inhibiting. edges: 0 = never clock,
    // 1..10 = abort after that many clocks, 11 = full frame with ACK level 'ack'.
    task automatic device(input logic ack, input int edges);
        rx_t r;
        int  n;
        r.inh = 0; r.inh_dat = 0; r.start = 1'b1; r.bits = '0;
        n = 0;
        while (!ps2_clk_oe && n < 100) begin @(negedge CLOCK_50); n++; end
        if (!ps2_clk_oe) begin
            chk("inhibit_seen", 0, 1);
            return;
        end
        while (ps2_clk_oe && r.inh < INH + 100) begin
            r.inh++;
            if (ps2_dat_oe) r.inh_dat++;
            @(negedge CLOCK_50);
        end
        r.start = bus_dat;
        if (edges == 0) return;
        for (int i = 1; i <= 10 && i <= edges; i++) begin
            repeat (H) @(negedge CLOCK_50);
            dev_clk = 1'b0;
            repeat (H) @(negedge CLOCK_50);
            dev_clk = 1'b1;
            r.bits[i-1] = bus_dat;
        end
        if (edges < 11) return;
        repeat (H/2) @(negedge CLOCK_50);
        dev_dat = ack;
        repeat (H/2) @(negedge CLOCK_50);
        dev_clk = 1'b0;
        repeat (H) @(negedge CLOCK_50);
        dev_clk = 1'b1;
        repeat (H/2) @(negedge CLOCK_50);
        dev_dat = 1'b1;
        rx_q.push_back(r);
    endtask

    task automatic check_frame(input int d0, input int e0);
        vec_t e;
        rx_t  r;
        if (exp_q.size() == 0) begin
            chk("expected_present", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        if (rx_q.size() == 0) begin
            chk("frame_received", 0, 1);
            return;
        end
        r = rx_q.pop_front();
        chk("inhibit_len", r.inh, INH);
        chk("start_on_last_inhibit", r.inh_dat, 1);
        chk("start_bit", int'(r.start), 0);
        chk("data_bits", int'(r.bits[7:0]), int'(e.data));
        chk("parity_bit", int'(r.bits[8]), int'(e.par));
        chk("stop_bit", int'(r.bits[9]), 1);
        chk("done_pulses", done_cnt - d0, int'(e.exp_done));
        chk("error_pulses", err_cnt - e0, int'(!e.exp_done));
        chk("ready_after", int'(tx_ready), 1);
    endtask

    task automatic run_vec(input vec_t v);
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        exp_q.push_back(v);
        send(v.data);
        device(v.ack, 11);
        repeat (40) @(negedge CLOCK_50);
        check_frame(d0, e0);
    endtask

    vec_t tbl[5];

    initial begin
        int d0, e0, s0, n;
        vec_t v;
        tbl[0] = '{PS2_CMD_SET_LED, 1'b0, 1'b1, 1'b1};
        tbl[1] = '{PS2_CMD_ENABLE,  1'b0, 1'b0, 1'b1};
        tbl[2] = '{8'h00,           1'b0, 1'b1, 1'b1};
        tbl[3] = '{PS2_CMD_RESET,   1'b0, 1'b1, 1'b1};
        tbl[4] = '{8'h5A,           1'b1, 1'b1, NACK_DONE};

        repeat (3) @(negedge CLOCK_50);
        chk("reset_ready", int'(tx_ready), 1);
        chk("reset_clk_oe", int'(ps2_clk_oe), 0);
        chk("reset_dat_oe", int'(ps2_dat_oe), 0);
        chk("reset_pulses", int'({tx_done, tx_error}), 0);
        reset = 1'b0;
        repeat (3) @(negedge CLOCK_50);

        for (int i = 0; i < 5; i++) run_vec(tbl[i]);

        // device never clocks: abort after TMO cycles of REQ
        d0 = done_cnt; e0 = err_cnt;
        send(8'hAB);
        device(1'b0, 0);
        n = 0;
        while (!tx_error && n < 2 * TMO) begin @(negedge CLOCK_50); n++; end
        chk("timeout_cycles", n, TMO);
        chk("timeout_clk_oe", int'(ps2_clk_oe), 0);
        chk("timeout_dat_oe", int'(ps2_dat_oe), 0);
        repeat (5) @(negedge CLOCK_50);
        chk("timeout_err_pulses", err_cnt - e0, 1);
        chk("timeout_done_pulses", done_cnt - d0, 0);

        // async reset mid-frame after clock edge 5 (data bit 4 of 0x00 holds the line low)
        send(8'h00);
        device(1'b0, 5);
        chk("dat_low_before_reset", int'(ps2_dat_oe), 1);
        #3 reset = 1'b1;
        #1;
        chk("reset_async_clk_oe", int'(ps2_clk_oe), 0);
        chk("reset_async_dat_oe", int'(ps2_dat_oe), 0);
        @(negedge CLOCK_50);
        reset = 1'b0;
        @(negedge CLOCK_50);
        chk("ready_after_reset", int'(tx_ready), 1);
        run_vec(tbl[1]);

        // tx_valid held through the frame, data changed during inhibit: one frame of 0x3C only
        v  = '{8'h3C, 1'b0, 1'b1, 1'b1};
        d0 = done_cnt; e0 = err_cnt; s0 = frame_starts;
        exp_q.push_back(v);
        @(negedge CLOCK_50);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        @(negedge CLOCK_50);
        tx_data  = 8'hC3;
        device(1'b0, 11);
        n = 0;
        while (!tx_done && n < 200) begin @(negedge CLOCK_50); n++; end
        tx_valid = 1'b0;
        repeat (40) @(negedge CLOCK_50);
        check_frame(d0, e0);
        chk("single_frame", frame_starts - s0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
